// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state
// encoding and the default operand width.
package mul_pkg;

    localparam int MUL_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } mul_state_e;

endpackage

// File: rtl/add_rc.sv
// add_rc: parameterised N-bit ripple-carry adder.
// Ports: a, b (N-bit addends), cin (carry in), s (N-bit sum), cout (carry out).
module add_rc #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/mul_shift_add.sv
// mul_shift_add: sequential unsigned shift-and-add multiplier, one
// multiplier bit per clock, WIDTH x WIDTH -> 2*WIDTH product.
// Ports: clk, rst (async active-high), start (sampled in IDLE),
//        a/b (operands captured on accepted start), busy (RUN state),
//        done (one-cycle pulse), product (held until next result).
// Optional: define MUL_EARLY_EXIT_EN to leave RUN as soon as the
//           remaining multiplier bits are all zero.
module mul_shift_add
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    mul_state_e      state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   product_q, product_d;

    logic [PW-1:0]   addend;
    logic [PW-1:0]   sum;
    logic            cout_unused;
    logic            last;

    // Only add the shifted multiplicand when the current multiplier bit is set.
    assign addend = mplier_q[0] ? mcand_q : '0;

    add_rc #(
        .N(PW)
    ) u_add (
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout_unused)
    );

`ifdef MUL_EARLY_EXIT_EN
    // Nothing left to accumulate once the post-shift multiplier is zero.
    assign last = (count_q == CW'(WIDTH - 1)) ||
                  (mplier_q[WIDTH-1:1] == '0);
`else
    assign last = (count_q == CW'(WIDTH - 1));
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            ST_RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (last) begin
                    state_d   = ST_DONE;
                    product_d = sum;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_mul_shift_add.sv
// Directed self-checking bench for mul_shift_add (WIDTH=8).
// Expected RUN lengths follow MUL_EARLY_EXIT_EN when it is defined.
module tb_mul_shift_add;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks;
    int errors;
    int n;

    mul_shift_add #(
        .WIDTH(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected number of RUN cycles for multiplier value bv.
    function automatic int exp_runs(input logic [7:0] bv);
        int r;
        r = 8;
`ifdef MUL_EARLY_EXIT_EN
        r = 1;
        for (int i = 0; i < 8; i++)
            if (bv[i]) r = i + 1;
`endif
        return r;
    endfunction

    // Present operands with start for one edge; returns in the first RUN cycle.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles (bounded); returns at the negedge after busy drops.
    task automatic run_wait(output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] av,
                         input logic [7:0] bv, input logic [15:0] pexp);
        start_op(av, bv);
        run_wait(n);
        chk({tag, "_runs"}, n, exp_runs(bv));
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_prod"}, product, pexp);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_prod", product, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        do_op("basic", 8'h0D, 8'h0B, 16'h008F);
        do_op("max", 8'hFF, 8'hFF, 16'hFE01);
        do_op("zero_b", 8'hFF, 8'h00, 16'h0000);

        // Second start during RUN must be ignored.
        start_op(8'h03, 8'h04);
        chk("bsy_run", busy, 1'b1);
        a = 8'h55;
        b = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_wait(n);
        chk("bsy_runs", n + 1, exp_runs(8'h04));
        chk("bsy_done", done, 1'b1);
        chk("bsy_prod", product, 16'h000C);
        // Start raised in the DONE cycle is not sampled.
        start = 1'b1;
        @(negedge clk);
        chk("dn_ign_busy", busy, 1'b0);
        chk("dn_ign_done", done, 1'b0);
        start = 1'b0;
        @(negedge clk);
        chk("dn_ign_busy2", busy, 1'b0);
        chk("dn_ign_prod", product, 16'h000C);

        // Asynchronous reset in the middle of RUN.
        start_op(8'h12, 8'h34);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", busy, 1'b0);
        chk("ar_done", done, 1'b0);
        chk("ar_prod", product, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        chk("ar_nodone", done, 1'b0);
        do_op("post_rst", 8'h02, 8'h03, 16'h0006);

        do_op("ee_b1", 8'h05, 8'h01, 16'h0005);
        do_op("ee_b80", 8'h05, 8'h80, 16'h0280);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
